product_display: RTL and testbench

//  Downstream of the radix-4 Booth multiplier. Captures the 16-bit product when the multiplier

---
 rtl/display_pkg.sv | 31 +++
 rtl/seg7_decoder.sv | 12 +
 rtl/product_display.sv | 122 ++++++++++++
 tb/tb_product_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the product display: digit count, state encodings and
// the active-high hex-to-segment table (bit 0 = segment a ... bit 6 = segment g).
package display_pkg;

    localparam int NDIG = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } disp_state_t;

    // Packed with entry 15 first so that HEX_SEG[n] is the pattern for digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // True when every nibble from position idx upward is zero, i.e. the digit
    // at idx is a leading zero. Position 0 is never treated as leading.
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] idx);
        logic lz;
        case (idx)
            2'd1:    lz = (v[15:4] == 12'h000);
            2'd2:    lz = (v[15:8] == 8'h00);
            2'd3:    lz = (v[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to 7-segment decode, active-high; output polarity is
// handled by the parent.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/product_display.sv
// Captures the multiplier product on a rising ready, acknowledges it with a
// one-cycle get, and scans it out as four hex digits on a muxed 7-seg display.
module product_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [15:0] product,
    input  logic        clr,
    output logic        get,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        held
);

    // state | meaning
    // EMPTY | nothing captured (or cleared); digits scan blank
    // SHOW  | a captured product is held and displayed

    localparam int               DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_OFF   = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

    disp_state_t      state, state_nxt;
    logic             ready_q;
    logic             rise;
    logic [15:0]      value;
    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic             wrap;
    logic [15:0]      shown_value;
    logic             shown_on;
    logic [3:0]       nib;
    logic [6:0]       seg_hex;
    logic [6:0]       seg_hi;
    logic [3:0]       an_hi;
    logic             blank;

    assign rise = ready & ~ready_q;
    assign wrap = (div == DIV_LAST);
    assign held = (state == SHOW);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A capture beats a simultaneous clear.
    always_comb begin
        state_nxt = state;
        if (rise) begin
            state_nxt = SHOW;
        end else if (clr) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
            value   <= 16'h0000;
            get     <= 1'b0;
        end else begin
            ready_q <= ready;
            get     <= rise;
            if (rise) begin
                value <= product;
            end
        end
    end

    // The shadow copy only moves at slot boundaries so a digit never changes
    // part-way through its slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div         <= '0;
            idx         <= 2'd0;
            shown_value <= 16'h0000;
            shown_on    <= 1'b0;
        end else if (wrap) begin
            div         <= '0;
            idx         <= idx + 2'd1;
            shown_value <= value;
            shown_on    <= (state == SHOW);
        end else begin
            div <= div + 1'b1;
        end
    end

    assign nib = 4'(shown_value >> {idx, 2'b00});

    seg7_decoder u_dec (
        .nib (nib),
        .seg (seg_hex)
    );

    always_comb begin
        blank  = ~shown_on | (BLANK_LZ & leading_zero(shown_value, idx));
        seg_hi = blank ? 7'h00 : seg_hex;
        an_hi  = 4'b0001 << idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            an  <= SEG_ACTIVE_LOW ? ~an_hi : an_hi;
        end
    end

endmodule

// File: tb/tb_product_display.sv
// Self-checking bench for product_display: table-driven captures plus
// hand-written sequences, with a queue of expected digit slots.
module tb_product_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [15:0] product;
    logic        clr;
    logic        get;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        held;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0]      product;
        logic [3:0][6:0]  segs;     // active-high patterns, {d3,d2,d1,d0}
    } vec_t;

    exp_t sb[$];

    product_display #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .BLANK_LZ       (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .product (product),
        .clr     (clr),
        .get     (get),
        .seg     (seg),
        .an      (an),
        .held    (held)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void push_disp(input logic [3:0][6:0] segs_hi);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.an  = ~(4'(1 << d));
            e.seg = ~segs_hi[d];
            sb.push_back(e);
        end
    endfunction

    // Waits for a digit-0 slot that starts after at least two slot boundaries,
    // then compares each queued slot and checks it stays steady for 4 cycles.
    task automatic drain(input string name);
        logic [3:0] prev, cur, a0;
        logic [6:0] s0;
        int bounds, budget;
        bit found, steady;
        exp_t e;
        bounds = 0; budget = 0; found = 0;
        @(negedge clk);
        prev = an;
        while (!found && budget < 64) begin
            @(negedge clk);
            budget++;
            cur = an;
            if (cur != prev) begin
                bounds++;
                if (bounds >= 2 && cur == 4'b1110) found = 1;
            end
            prev = cur;
        end
        if (!found) begin
            checks++;
            $display("FAIL %s_sync: got an=%b after 64 cycles, expected a digit-0 slot", name, an);
            sb.delete();
            return;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a0 = an; s0 = seg; steady = 1;
            for (int k = 1; k < 4; k++) begin
                @(negedge clk);
                if (an !== a0 || seg !== s0) steady = 0;
            end
            checks++;
            if (a0 === e.an && s0 === e.seg && steady) passed++;
            else $display("FAIL %s: got an=%b seg=%h steady=%0d expected an=%b seg=%h steady=1",
                          name, a0, s0, steady, e.an, e.seg);
            @(negedge clk);
        end
    endtask

    // Raises ready for two cycles with a new product and checks the get pulse.
    task automatic capture(input string name, input logic [15:0] p, input logic with_clr);
        @(negedge clk);
        product = p;
        ready = 1'b1;
        clr = with_clr;
        @(posedge clk); #1;
        chk({name, "_get_hi"}, {31'd0, get}, 32'd1);
        chk({name, "_held"}, {31'd0, held}, 32'd1);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        chk({name, "_get_lo"}, {31'd0, get}, 32'd0);
        @(negedge clk);
        ready = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        int gets;
        vecs[0] = '{16'h1A2F, {7'h06, 7'h77, 7'h5B, 7'h71}};
        vecs[1] = '{16'h0005, {7'h00, 7'h00, 7'h00, 7'h6D}};
        vecs[2] = '{16'h0000, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{16'h0D00, {7'h00, 7'h5E, 7'h3F, 7'h3F}};
        vecs[4] = '{16'hBEEF, {7'h7C, 7'h79, 7'h79, 7'h71}};

        rst = 1'b0; ready = 1'b0; product = 16'h0000; clr = 1'b0;

        // Reset for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_get_held", {30'd0, get, held}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push_disp('0);
        drain("idle_scan");

        // Table of captures
        foreach (vecs[i]) begin
            capture($sformatf("cap_%04h", vecs[i].product), vecs[i].product, 1'b0);
            push_disp(vecs[i].segs);
            drain($sformatf("disp_%04h", vecs[i].product));
        end

        // ready held high across a product change gives a single capture
        @(negedge clk);
        product = 16'h1234;
        ready = 1'b1;
        gets = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (get) gets++;
            @(negedge clk);
            if (c == 4) product = 16'h5678;
        end
        chk("hold_one_get", gets, 32'd1);
        ready = 1'b0;
        push_disp({7'h06, 7'h5B, 7'h4F, 7'h66});
        drain("hold_disp_1234");
        capture("recap_5678", 16'h5678, 1'b0);
        push_disp({7'h6D, 7'h7D, 7'h07, 7'h7F});
        drain("disp_5678");

        // clr alone, then clr together with a rise
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_held", {31'd0, held}, 32'd0);
        chk("clr_get", {31'd0, get}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        push_disp('0);
        drain("clr_blank");
        capture("clr_and_rise", 16'h00C0, 1'b1);
        push_disp({7'h00, 7'h00, 7'h39, 7'h3F});
        drain("disp_00c0");

        // Reset mid-slot of digit 2
        begin
            int budget;
            budget = 0;
            @(negedge clk);
            while (an !== 4'b1011 && budget < 32) begin
                @(negedge clk);
                budget++;
            end
            chk("mid_rst_reach_d2", {28'd0, an}, 32'hB);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_get_held", {30'd0, get, held}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        begin
            bit steady;
            steady = 1;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (an !== 4'b1110 || seg !== 7'h7F) steady = 0;
            end
            chk("restart_slot0", {31'd0, steady}, 32'd1);
            @(posedge clk); #1;
            chk("restart_slot1_an", {28'd0, an}, 32'hD);
            chk("restart_held", {31'd0, held}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
